// File: rtl/mult_arb_pkg.sv
// Shared types and helpers for the multiplier arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents: arb_state_t FSM encoding, operand/result widths, parity_ok().
package mult_arb_pkg;

    localparam int OP_W  = 16;
    localparam int RES_W = 32;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE    = 2'd1,
        WAIT_RES = 2'd2,
        DONE     = 2'd3
    } arb_state_t;

    // An operand is valid when its parity bit equals the XOR of its bits.
    function automatic logic parity_ok(input logic [OP_W-1:0] data, input logic parity);
        return ((^data) == parity);
    endfunction

endpackage

// File: rtl/mult_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request after i_ptr, wrapping.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; o_vld simply reflects whether any request is set.
//
// Ports: i_req (request vector), i_ptr (last granted index),
//        o_vld (some request present), o_idx (chosen index).
module rr_pick #(
    parameter int N_REQ = 4,
    parameter int IDX_W = 2
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic             o_vld,
    output logic [IDX_W-1:0] o_idx
);

    // Index reached by stepping k positions past ptr, modulo N_REQ.
    function automatic logic [IDX_W-1:0] step_idx(input logic [IDX_W-1:0] ptr, input int k);
        int j;
        j = int'(ptr) + k;
        if (j >= N_REQ) begin
            j = j - N_REQ;
        end
        return j[IDX_W-1:0];
    endfunction

    // Scan from the farthest position back to ptr+1 so the nearest
    // requester after ptr is the last (and winning) assignment.
    always_comb begin
        o_vld = 1'b0;
        o_idx = '0;
        for (int k = N_REQ; k >= 1; k--) begin
            if (i_req[step_idx(i_ptr, k)]) begin
                o_vld = 1'b1;
                o_idx = step_idx(i_ptr, k);
            end
        end
    end

endmodule

// File: rtl/mult_arbiter.sv
// Round-robin arbiter sharing one parity-checked 16x16 signed multiplier among N_REQ clients.
// Latency: cli_req->cli_ack 1 cycle; cli_ack->cli_rdy multiplier latency plus FSM overhead.
// Backpressure: clients hold cli_req until cli_ack; watchdog aborts after TIMEOUT cycles.
//
// Ports: clk/rst_n (async active-low); cli_* client side (packed 16-bit operands per client,
// one-hot ack/rdy pulses, result and flags held between rdy pulses); m_* multiplier side
// (req/ack/result_rdy handshake); busy high whenever the FSM is not IDLE.
// Option: define MULT_ARB_PARITY_CHECK_EN to reject bad-parity operands locally without
// issuing them to the multiplier.
module mult_arbiter
    import mult_arb_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_REQ-1:0]      cli_req,
    input  logic [OP_W*N_REQ-1:0] cli_arg_a,
    input  logic [N_REQ-1:0]      cli_arg_a_parity,
    input  logic [OP_W*N_REQ-1:0] cli_arg_b,
    input  logic [N_REQ-1:0]      cli_arg_b_parity,
    output logic [N_REQ-1:0]      cli_ack,
    output logic [N_REQ-1:0]      cli_rdy,
    output logic [RES_W-1:0]      cli_result,
    output logic                  cli_result_parity,
    output logic                  cli_arg_parity_error,
    output logic                  cli_timeout,
    output logic                  m_req,
    output logic [OP_W-1:0]       m_arg_a,
    output logic [OP_W-1:0]       m_arg_b,
    output logic                  m_arg_a_parity,
    output logic                  m_arg_b_parity,
    input  logic                  m_ack,
    input  logic [RES_W-1:0]      m_result,
    input  logic                  m_result_parity,
    input  logic                  m_arg_parity_error,
    input  logic                  m_result_rdy,
    output logic                  busy
);

    localparam int IDX_W = $clog2(N_REQ);
    localparam int WD_W  = $clog2(TIMEOUT + 1);

    arb_state_t       r_state;
    arb_state_t       w_state_nxt;

    logic [IDX_W-1:0] r_ptr;
    logic [IDX_W-1:0] r_idx;
    logic [IDX_W-1:0] w_pick_idx;
    logic             w_pick_vld;
    logic [N_REQ-1:0] w_pick_oh;
    logic [N_REQ-1:0] w_idx_oh;

    logic [OP_W-1:0]  w_sel_a;
    logic [OP_W-1:0]  w_sel_b;
    logic             w_sel_pa;
    logic             w_sel_pb;

    logic [WD_W-1:0]  r_wdog;
    logic             w_wd_expire;

    // One-cycle strobes from the FSM to the datapath.
    logic             w_grant;
    logic             w_done_res;
    logic             w_done_to;
    logic             w_done_perr;

    logic [N_REQ-1:0] r_ack;
    logic [N_REQ-1:0] r_rdy;
    logic [RES_W-1:0] r_result;
    logic             r_res_par;
    logic             r_perr;
    logic             r_to;
    logic             r_m_req;
    logic [OP_W-1:0]  r_m_a;
    logic [OP_W-1:0]  r_m_b;
    logic             r_m_pa;
    logic             r_m_pb;

    rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .i_req (cli_req),
        .i_ptr (r_ptr),
        .o_vld (w_pick_vld),
        .o_idx (w_pick_idx)
    );

    assign w_sel_a     = cli_arg_a[w_pick_idx*OP_W +: OP_W];
    assign w_sel_b     = cli_arg_b[w_pick_idx*OP_W +: OP_W];
    assign w_sel_pa    = cli_arg_a_parity[w_pick_idx];
    assign w_sel_pb    = cli_arg_b_parity[w_pick_idx];
    assign w_pick_oh   = {{(N_REQ-1){1'b0}}, 1'b1} << w_pick_idx;
    assign w_idx_oh    = {{(N_REQ-1){1'b0}}, 1'b1} << r_idx;
    // The TIMEOUT-th cycle spent in ISSUE/WAIT_RES is the last one allowed.
    assign w_wd_expire = (r_wdog == WD_W'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        w_done_res  = 1'b0;
        w_done_to   = 1'b0;
        w_done_perr = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_pick_vld) begin
                    w_grant = 1'b1;
`ifdef MULT_ARB_PARITY_CHECK_EN
                    if (!parity_ok(w_sel_a, w_sel_pa) || !parity_ok(w_sel_b, w_sel_pb)) begin
                        w_done_perr = 1'b1;
                        w_state_nxt = DONE;
                    end else begin
                        w_state_nxt = ISSUE;
                    end
`else
                    w_state_nxt = ISSUE;
`endif
                end
            end
            ISSUE: begin
                // A same-cycle ack and result completes without visiting WAIT_RES.
                if (m_ack && m_result_rdy) begin
                    w_done_res  = 1'b1;
                    w_state_nxt = DONE;
                end else if (w_wd_expire) begin
                    w_done_to   = 1'b1;
                    w_state_nxt = DONE;
                end else if (m_ack) begin
                    w_state_nxt = WAIT_RES;
                end
            end
            WAIT_RES: begin
                if (m_result_rdy) begin
                    w_done_res  = 1'b1;
                    w_state_nxt = DONE;
                end else if (w_wd_expire) begin
                    w_done_to   = 1'b1;
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr    <= IDX_W'(N_REQ - 1);
            r_idx    <= '0;
            r_ack    <= '0;
            r_rdy    <= '0;
            r_result <= '0;
            r_res_par <= 1'b0;
            r_perr   <= 1'b0;
            r_to     <= 1'b0;
            r_m_req  <= 1'b0;
            r_m_a    <= '0;
            r_m_b    <= '0;
            r_m_pa   <= 1'b0;
            r_m_pb   <= 1'b0;
            r_wdog   <= '0;
        end else begin
            r_ack   <= '0;
            r_rdy   <= '0;
            // m_req tracks residence in ISSUE, so it drops the cycle after m_ack.
            r_m_req <= (w_state_nxt == ISSUE);

            if (w_grant) begin
                r_idx  <= w_pick_idx;
                r_ptr  <= w_pick_idx;
                r_ack  <= w_pick_oh;
                r_m_a  <= w_sel_a;
                r_m_b  <= w_sel_b;
                r_m_pa <= w_sel_pa;
                r_m_pb <= w_sel_pb;
                r_wdog <= '0;
            end else if (r_state == ISSUE || r_state == WAIT_RES) begin
                r_wdog <= r_wdog + 1'b1;
            end

            if (w_done_res) begin
                r_result  <= m_result;
                r_res_par <= m_result_parity;
                r_perr    <= m_arg_parity_error;
                r_to      <= 1'b0;
                r_rdy     <= w_idx_oh;
            end

            if (w_done_to) begin
                r_result  <= '0;
                r_res_par <= 1'b0;
                r_perr    <= 1'b0;
                r_to      <= 1'b1;
                r_rdy     <= w_idx_oh;
            end

            // Index is not registered yet in this cycle, so use the live pick.
            if (w_done_perr) begin
                r_result  <= '0;
                r_res_par <= 1'b0;
                r_perr    <= 1'b1;
                r_to      <= 1'b0;
                r_rdy     <= w_pick_oh;
            end
        end
    end

    assign cli_ack              = r_ack;
    assign cli_rdy              = r_rdy;
    assign cli_result           = r_result;
    assign cli_result_parity    = r_res_par;
    assign cli_arg_parity_error = r_perr;
    assign cli_timeout          = r_to;
    assign m_req                = r_m_req;
    assign m_arg_a              = r_m_a;
    assign m_arg_b              = r_m_b;
    assign m_arg_a_parity       = r_m_pa;
    assign m_arg_b_parity       = r_m_pb;
    assign busy                 = (r_state != IDLE);

endmodule
